// File: rtl/pio_pkg.sv
// Shared PIO host-side definitions: action-bus encodings, drain FSM states and a
// round-robin pointer helper used by the RX drain and TX fill blocks.
package pio_pkg;

  localparam logic [3:0] ActNone  = 4'd0;
  localparam logic [3:0] ActInstr = 4'd1;
  localparam logic [3:0] ActPend  = 4'd2;
  localparam logic [3:0] ActPull  = 4'd3;
  localparam logic [3:0] ActPush  = 4'd4;
  localparam logic [3:0] ActGrps  = 4'd5;
  localparam logic [3:0] ActEn    = 4'd6;
  localparam logic [3:0] ActDiv   = 4'd7;
  localparam logic [3:0] ActSides = 4'd8;
  localparam logic [3:0] ActImm   = 4'd9;
  localparam logic [3:0] ActShift = 4'd10;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StArb  = 3'd1;
  localparam logic [2:0] StPull = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StHold = 3'd4;

  // Next machine index after idx, wrapping at n machines.
  function automatic logic [1:0] rr_next(input logic [1:0] idx, input int unsigned n);
    int unsigned t;
    t = 32'(idx) + 32'd1;
    if (t >= n) return 2'd0;
    return 2'(t);
  endfunction

endpackage

// File: rtl/pio_rr_arb.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping at N.
module pio_rr_arb #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    eligible,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  always_comb begin
    int unsigned j;
    j   = 0;
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && eligible[IdxW'(j)]) begin
        any = 1'b1;
        idx = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/pio_rx_drain.sv
// Drains PIO RX FIFOs via PULL actions and streams the extracted characters out.
// Optional handshake counter (stat_cnt/stat_clr) when PIO_RX_DRAIN_STATS_EN is defined.
module pio_rx_drain
  import pio_pkg::*;
#(
  parameter int unsigned NUM_SM   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LSB_POS  = 24,
  parameter int unsigned DOUT_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NUM_SM-1:0] sm_mask,
  input  logic              gnt,
  input  logic [3:0]        rx_empty,
  input  logic [31:0]       dout,
  output logic [3:0]        action,
  output logic [1:0]        mindex,
  output logic [31:0]       din,
  output logic              req,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        m_sm
`ifdef PIO_RX_DRAIN_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_cnt
`endif
);

  localparam logic [1:0] LatLast = 2'(DOUT_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        mindex_q, mindex_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        lat_q, lat_d;
  logic [1:0]        m_sm_q, m_sm_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;

  logic [NUM_SM-1:0] elig;
  logic [1:0]        arb_ptr, arb_idx;
  logic              arb_any;
  logic              pull_fire, hs;

  // Only the character field of dout and the low NUM_SM empty flags matter.
  logic unused_inputs;
  assign unused_inputs = ^{dout, rx_empty};

  assign elig      = en ? (sm_mask & ~rx_empty[NUM_SM-1:0]) : '0;
  // In HOLD the pick uses the post-handshake pointer so the next pull needs no bubble.
  assign arb_ptr   = (state_q == StHold) ? rr_next(m_sm_q, NUM_SM) : ptr_q;
  assign pull_fire = (state_q == StPull) && gnt;
  assign hs        = (state_q == StHold) && m_ready;

  pio_rr_arb #(
    .N    (NUM_SM),
    .IdxW (2)
  ) u_arb (
    .eligible (elig),
    .ptr      (arb_ptr),
    .idx      (arb_idx),
    .any      (arb_any)
  );

  always_comb begin
    state_d  = state_q;
    mindex_d = mindex_q;
    ptr_d    = ptr_q;
    lat_d    = lat_q;
    m_sm_d   = m_sm_q;
    m_data_d = m_data_q;
    case (state_q)
      StIdle: begin
        if (arb_any) begin
          state_d  = StArb;
          mindex_d = arb_idx;
        end
      end
      StArb: begin
        if (!en || rx_empty[mindex_q]) begin
          state_d = StIdle;
        end else if (gnt) begin
          state_d = StPull;
        end
      end
      StPull: begin
        if (gnt) begin
          state_d = StWait;
          lat_d   = 2'd0;
        end else begin
          state_d = StArb;
        end
      end
      StWait: begin
        if (lat_q == LatLast) begin
          state_d  = StHold;
          m_data_d = dout[LSB_POS +: DATA_W];
          m_sm_d   = mindex_q;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StHold: begin
        if (hs) begin
          ptr_d = arb_ptr;
          if (arb_any) begin
            state_d  = StArb;
            mindex_d = arb_idx;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mindex_q <= 2'd0;
      ptr_q    <= 2'd0;
      lat_q    <= 2'd0;
      m_sm_q   <= 2'd0;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      mindex_q <= mindex_d;
      ptr_q    <= ptr_d;
      lat_q    <= lat_d;
      m_sm_q   <= m_sm_d;
      m_data_q <= m_data_d;
    end
  end

  assign action  = pull_fire ? ActPull : ActNone;
  assign din     = {31'd0, pull_fire};
  assign req     = (state_q == StArb) || (state_q == StPull);
  assign mindex  = mindex_q;
  assign m_valid = (state_q == StHold);
  assign m_data  = m_data_q;
  assign m_sm    = m_sm_q;

`ifdef PIO_RX_DRAIN_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_q <= 32'd0;
    end else if (stat_clr) begin
      stat_q <= 32'd0;
    end else if (hs) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stat_cnt = stat_q;
`else
  // Statistics counter not built.
`endif

endmodule

// File: tb/tb_pio_rx_drain.sv
// Bench for pio_rx_drain: a PIO RX FIFO model feeds dout, a scoreboard checks the stream.
module tb_pio_rx_drain;
  import pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset, en, gnt, m_ready;
  logic [3:0]  sm_mask, rx_empty;
  logic [31:0] dout;
  logic [3:0]  action;
  logic [1:0]  mindex, m_sm;
  logic [31:0] din;
  logic        req, m_valid;
  logic [7:0]  m_data;
`ifdef PIO_RX_DRAIN_STATS_EN
  logic        stat_clr, nx_clr;
  logic [31:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  pio_rx_drain u_dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sm_mask  (sm_mask),
    .gnt      (gnt),
    .rx_empty (rx_empty),
    .dout     (dout),
    .action   (action),
    .mindex   (mindex),
    .din      (din),
    .req      (req),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_sm     (m_sm)
`ifdef PIO_RX_DRAIN_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt)
`endif
  );

  int checks = 0, errors = 0, hs_cnt = 0, pull_cnt = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  sb_e;
  logic [31:0] mem[4][8];
  logic [3:0]  rd[4], wr[4];
  logic        pend;
  logic [1:0]  pidx;
  logic        nx_gnt, nx_ready, nx_en;
  logic [3:0]  nx_mask;
  logic [3:0]  s_action;
  logic [1:0]  s_mindex;
  logic [31:0] s_din;
  logic        s_req, s_valid;
  logic [7:0]  s_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic load(input logic [1:0] sm, input logic [31:0] w);
    mem[sm][wr[sm][2:0]] = w;
    wr[sm] = wr[sm] + 4'd1;
  endtask

  task automatic expect_char(input logic [1:0] sm, input logic [7:0] d);
    exp_q.push_back({sm, d});
  endtask

  task automatic clear_model();
    pend = 1'b0;
    for (int n = 0; n < 4; n++) begin
      rd[n] = 4'd0;
      wr[n] = 4'd0;
    end
    rx_empty = 4'hF;
  endtask

  // One cycle: apply model/stimulus just after the rising edge, sample after the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pend) begin
      check("pull_nonempty", 32'(rd[pidx] != wr[pidx]), 32'd1);
      dout     = mem[pidx][rd[pidx][2:0]];
      rd[pidx] = rd[pidx] + 4'd1;
      pend     = 1'b0;
    end
    for (int n = 0; n < 4; n++) rx_empty[n] = (rd[n] == wr[n]);
    gnt     = nx_gnt;
    m_ready = nx_ready;
    en      = nx_en;
    sm_mask = nx_mask;
`ifdef PIO_RX_DRAIN_STATS_EN
    stat_clr = nx_clr;
`endif
    @(negedge clk);
    #1;
    s_action = action;
    s_mindex = mindex;
    s_din    = din;
    s_req    = req;
    s_valid  = m_valid;
    s_data   = m_data;
    if (action == ActPull) begin
      pend = 1'b1;
      pidx = mindex;
      pull_cnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every accepted character must match the next expected one.
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got sm %0d data %0h, want no character", m_sm, m_data);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_sm", 32'(m_sm), 32'(sb_e[9:8]));
        check("sb_data", 32'(m_data), 32'(sb_e[7:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int base_p, base_h;
    logic [8:0] gseq;
    reset    = 1'b1;
    en       = 1'b1;
    gnt      = 1'b0;
    m_ready  = 1'b0;
    sm_mask  = 4'hF;
    dout     = 32'd0;
    nx_gnt   = 1'b1;
    nx_ready = 1'b1;
    nx_en    = 1'b1;
    nx_mask  = 4'hF;
`ifdef PIO_RX_DRAIN_STATS_EN
    stat_clr = 1'b0;
    nx_clr   = 1'b0;
`endif
    clear_model();
    #2;
    check("rst_action", 32'(action), 32'd0);
    check("rst_mindex", 32'(mindex), 32'd0);
    check("rst_din", din, 32'd0);
    check("rst_req", 32'(req), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_sm", 32'(m_sm), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single byte with cycle-accurate timing.
    load(2'd0, 32'hA500_0000);
    expect_char(2'd0, 8'hA5);
    tick();
    check("t1_idle_req", 32'(s_req), 32'd0);
    tick();
    check("t1_arb_req", 32'(s_req), 32'd1);
    check("t1_arb_act", 32'(s_action), 32'd0);
    tick();
    check("t1_pull_act", 32'(s_action), 32'd3);
    check("t1_pull_idx", 32'(s_mindex), 32'd0);
    check("t1_pull_din", s_din, 32'd1);
    tick();
    check("t1_wait_act", 32'(s_action), 32'd0);
    check("t1_wait_req", 32'(s_req), 32'd0);
    check("t1_wait_valid", 32'(s_valid), 32'd0);
    tick();
    check("t1_hold_valid", 32'(s_valid), 32'd1);
    check("t1_hold_data", 32'(s_data), 32'hA5);
    tick();

    // Backpressure: one outstanding pull only, data held stable.
    load(2'd0, 32'h1100_00FF);
    load(2'd0, 32'h2233_4455);
    expect_char(2'd0, 8'h11);
    expect_char(2'd0, 8'h22);
    nx_ready = 1'b0;
    base_p   = pull_cnt;
    repeat (14) tick();
    check("bp_pulls", 32'(pull_cnt - base_p), 32'd1);
    check("bp_valid", 32'(s_valid), 32'd1);
    check("bp_data", 32'(s_data), 32'h11);
    nx_ready = 1'b1;
    repeat (6) tick();
    check("bp_pulls_after", 32'(pull_cnt - base_p), 32'd2);

    // Round-robin across all machines at full throughput.
    do_reset();
    load(2'd0, 32'h1000_0001);
    load(2'd1, 32'h2100_0002);
    load(2'd2, 32'h3200_0003);
    load(2'd3, 32'h4300_0004);
    load(2'd0, 32'h1400_0005);
    expect_char(2'd0, 8'h10);
    expect_char(2'd1, 8'h21);
    expect_char(2'd2, 8'h32);
    expect_char(2'd3, 8'h43);
    expect_char(2'd0, 8'h14);
    base_h = hs_cnt;
    repeat (21) tick();
    check("rr_hs", 32'(hs_cnt - base_h), 32'd5);

    // Masked round-robin: machines 1 and 3 never pulled.
    do_reset();
    nx_mask = 4'b0101;
    load(2'd0, 32'h0A00_0000);
    load(2'd0, 32'h0B00_0000);
    load(2'd2, 32'h2A00_0000);
    load(2'd2, 32'h2B00_0000);
    load(2'd1, 32'hEE00_0000);
    load(2'd3, 32'hEF00_0000);
    expect_char(2'd0, 8'h0A);
    expect_char(2'd2, 8'h2A);
    expect_char(2'd0, 8'h0B);
    expect_char(2'd2, 8'h2B);
    base_h = hs_cnt;
    base_p = pull_cnt;
    repeat (17) tick();
    check("mask_hs", 32'(hs_cnt - base_h), 32'd4);
    check("mask_pulls", 32'(pull_cnt - base_p), 32'd4);

    // Grant loss in the PULL cycle.
    do_reset();
    nx_mask = 4'hF;
    load(2'd1, 32'h5A00_1234);
    expect_char(2'd1, 8'h5A);
    base_h = hs_cnt;
    base_p = pull_cnt;
    gseq   = 9'b1_1111_0011;
    for (int i = 0; i < 9; i++) begin
      nx_gnt = gseq[i];
      tick();
      if (i == 1) check("gl_arb_req", 32'(s_req), 32'd1);
      if (i == 2) begin
        check("gl_drop_act", 32'(s_action), 32'd0);
        check("gl_drop_req", 32'(s_req), 32'd1);
      end
      if (i == 3) check("gl_rearb_req", 32'(s_req), 32'd1);
      if (i == 5) begin
        check("gl_pull_act", 32'(s_action), 32'd3);
        check("gl_pull_idx", 32'(s_mindex), 32'd1);
      end
    end
    check("gl_pulls", 32'(pull_cnt - base_p), 32'd1);
    check("gl_hs", 32'(hs_cnt - base_h), 32'd1);

    // Asynchronous reset mid-WAIT after the pointer has moved to 3.
    do_reset();
    nx_gnt = 1'b1;
    load(2'd2, 32'h3C00_0000);
    expect_char(2'd2, 8'h3C);
    repeat (6) tick();
    load(2'd2, 32'h9900_0000);
    repeat (4) tick();
    check("rw_pre_idx", 32'(s_mindex), 32'd2);
    reset = 1'b1;
    #1;
    check("rw_act", 32'(action), 32'd0);
    check("rw_valid", 32'(m_valid), 32'd0);
    check("rw_mindex", 32'(mindex), 32'd0);
    check("rw_req", 32'(req), 32'd0);
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    load(2'd1, 32'hC100_0000);
    load(2'd3, 32'hD300_0000);
    expect_char(2'd1, 8'hC1);
    expect_char(2'd3, 8'hD3);
    base_h = hs_cnt;
    repeat (10) tick();
    check("rw_hs", 32'(hs_cnt - base_h), 32'd2);

`ifdef PIO_RX_DRAIN_STATS_EN
    do_reset();
    load(2'd0, 32'h6100_0000);
    load(2'd1, 32'h6200_0000);
    load(2'd2, 32'h6300_0000);
    expect_char(2'd0, 8'h61);
    expect_char(2'd1, 8'h62);
    expect_char(2'd2, 8'h63);
    repeat (13) tick();
    check("st_cnt3", stat_cnt, 32'd3);
    nx_ready = 1'b0;
    load(2'd0, 32'h4400_0000);
    expect_char(2'd0, 8'h44);
    repeat (6) tick();
    nx_ready = 1'b1;
    nx_clr   = 1'b1;
    tick();
    nx_clr = 1'b0;
    tick();
    check("st_clr_prio", stat_cnt, 32'd0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_rx_drain.md
Name: pio_rx_drain

Overview:
- Downstream consumer of the PIO block's RX FIFOs.
- When `en` is high and `gnt` is granted, watches `rx_empty`, issues PULL actions on the PIO host action bus, captures `dout`, and extracts the received character (for example a UART RX byte).
- Presents the character on a valid/ready stream tagged with the source state machine index.
- Sits between `pio` and the SoC-side byte sink (CPU register, FIFO or USB bridge).

Parameters:
- NUM_SM, 4, number of PIO state machines scanned (1..4).
- DATA_W, 8, width of the extracted character.
- LSB_POS, 24, bit position in `dout` of the character LSB (right-shifting ISR, 8 bits -> [31:24]).
- DOUT_LAT, 1, cycles from the PULL action cycle to valid `dout` (1..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  drain enable; when low, no new PULL is issued.
- sm_mask  in  NUM_SM  per-machine enable mask.
- gnt  in  1  action-bus grant from the host mux (config master has priority).
- rx_empty  in  4  from pio; bit n high = RX FIFO n empty.
- dout  in  32  from pio; RX data.
- action  out  4  to pio; 3 (PULL) during request, else 0 (NONE).
- mindex  out  2  to pio; machine being pulled.
- din  out  32  to pio; constant 1 during PULL, else 0.
- req  out  1  action-bus request to the host mux.
- m_valid  out  1  character valid.
- m_ready  in  1  sink ready.
- m_data  out  DATA_W  character = dout[LSB_POS+DATA_W-1:LSB_POS].
- m_sm  out  2  source machine index.

Behaviour:
- Reset (async, immediate): state IDLE; action=0, mindex=0, din=0, req=0, m_valid=0, m_data=0, m_sm=0; round-robin pointer = 0.
- States are IDLE, ARB, PULL, WAIT, HOLD.
- IDLE -> ARB when en=1 and some n has sm_mask[n]=1 and rx_empty[n]=0.
  - Target n is the first eligible machine at or after the pointer, wrapping modulo NUM_SM.
  - The target is latched into mindex.
  - req goes high in ARB.
- ARB -> PULL on the first cycle gnt=1. req stays high while waiting.
- If the latched machine's rx_empty goes high or en drops while in ARB, return to IDLE and drop req.
- PULL lasts exactly one cycle: action=3, din=1, mindex=latched.
  - PULL is issued only if gnt=1 in that cycle.
  - If gnt has dropped, action=0 and the state returns to ARB.
- WAIT lasts DOUT_LAT cycles, then dout is captured into m_data and m_sm. State goes to HOLD with m_valid=1. req is low from WAIT onward.
- HOLD: m_valid, m_data and m_sm are stable until m_valid&&m_ready.
  - On handshake: m_valid=0, pointer = m_sm+1 mod NUM_SM.
  - If another machine is eligible in that same cycle, go to ARB directly (zero-bubble); otherwise go to IDLE.
- Throughput: one character per 3+DOUT_LAT cycles, given gnt held and m_ready=1.
- Only one PULL is outstanding; a new PULL is never issued while m_valid=1. The block therefore never loses a word.
- en low during WAIT/HOLD: the current character completes and is delivered. en only gates new requests.
- sm_mask bits beyond NUM_SM are ignored. rx_empty bits for n>=NUM_SM are ignored.

Optional Feature:
- Macro: PIO_RX_DRAIN_STATS_EN.
- When defined, adds output `stat_cnt` (out, 32) and input `stat_clr` (in, 1).
  - `stat_cnt` counts handshaken characters and wraps at 2^32.
  - `stat_clr` is a synchronous clear and takes priority over the increment in the same cycle.
  - The count resets to 0 on reset.
- When undefined, neither port exists and there is no counter logic.

Decomposition:
- Shared package pio_pkg:
  - action encodings NONE=0, INSTR=1, PEND=2, PULL=3, PUSH=4, GRPS=5, EN=6, DIV=7, SIDES=8, IMM=9, SHIFT=10.
  - state enum for this block.
- One natural sub-module: pio_rr_arb.
  - Combinational round-robin picker: inputs are eligible vector and pointer; outputs are grant index and any.
  - Reusable by the TX-side filler block.

Test Plan:
- Single byte: rx_empty=4'b1110, dout=32'hA5000000 at DOUT_LAT, gnt=1, m_ready=1 -> action=3/mindex=0 for exactly one cycle; m_valid with m_data=8'hA5, m_sm=0 four cycles after request.
- Backpressure: m_ready=0 for 10 cycles with rx_empty[0]=0 -> exactly one PULL issued; m_data stable; the second PULL is issued only after the handshake.
- Round-robin: rx_empty=4'b0000 held, m_ready=1 -> m_sm sequence 0,1,2,3,0; with sm_mask=4'b0101 the sequence is 0,2,0,2.
- Grant loss: gnt=1 in ARB, 0 in the PULL cycle -> action stays 0; back to ARB; PULL issued when gnt returns; one character delivered.
- Reset mid-WAIT: assert reset asynchronously -> action=0, m_valid=0 immediately; after release, state IDLE and the pointer restarts at 0.
- STATS_EN: deliver 3 characters -> stat_cnt=3; stat_clr together with a handshake -> stat_cnt=0.
